// File: rtl/caf_axi_pkg.sv
// Shared types and helpers for the CAF AXI-style initiators: FSM state
// encoding, default widths and the transfer-length clamp.
package caf_axi_pkg;

   localparam int CAF_BUFFER_LENGTH  = 10;
   localparam int CAF_INDEX_BITS     = 4;
   localparam int CAF_I_BITS         = 12;
   localparam int CAF_Q_BITS         = 12;
   localparam int IQ_BITS            = CAF_I_BITS + CAF_Q_BITS;
   localparam int CAF_TIMEOUT_CYCLES = 16;

   typedef enum logic [3:0] {
      IDLE,
      WR_ACCEPT,
      WR_REQ,
      WR_RESP,
      RD_REQ,
      RD_WAIT,
      RD_OUT,
      RD_ACK,
      DONE
   } state_e;

   // Zero or out-of-range requests mean "the whole buffer".
   function automatic int clamp_len(input int req, input int max_len);
      return (req == 0 || req > max_len) ? max_len : req;
   endfunction

endpackage

// File: rtl/capture_buffer_master_if.sv
// Write/read channel bundle between the capture buffer initiator and the
// I/Q capture buffer responder.
interface capture_buffer_master_if #(
   parameter int INDEX_BITS = 4,
   parameter int I_BITS     = 12,
   parameter int Q_BITS     = 12
);
   logic [INDEX_BITS-1:0]    m_axi_waddr;
   logic                     m_axi_wvalid;
   logic [I_BITS+Q_BITS-1:0] m_axi_wdata;
   logic                     s_axi_wready;
   logic                     s_axi_bvalid;
   logic                     s_axi_bresp;
   logic                     m_axi_bready;
   logic [INDEX_BITS-1:0]    m_axi_raddr;
   logic                     m_axi_rvalid;
   logic                     m_axi_rready;
   logic                     s_axi_rvalid;
   logic                     s_axi_rready;
   logic [I_BITS-1:0]        s_i;
   logic [Q_BITS-1:0]        s_q;

   modport master (
      output m_axi_waddr, m_axi_wvalid, m_axi_wdata, m_axi_bready,
      output m_axi_raddr, m_axi_rvalid, m_axi_rready,
      input  s_axi_wready, s_axi_bvalid, s_axi_bresp,
      input  s_axi_rvalid, s_axi_rready, s_i, s_q
   );

   modport slave (
      input  m_axi_waddr, m_axi_wvalid, m_axi_wdata, m_axi_bready,
      input  m_axi_raddr, m_axi_rvalid, m_axi_rready,
      output s_axi_wready, s_axi_bvalid, s_axi_bresp,
      output s_axi_rvalid, s_axi_rready, s_i, s_q
   );
endinterface

// File: rtl/capture_buffer_master_timeout_counter.sv
// Response watchdog: counts enabled cycles since the last load and flags
// expiry on the LIMIT-th consecutive enabled cycle.
module timeout_counter #(
   parameter int LIMIT = 16
) (
   input  logic clk,
   input  logic rst_n,
   input  logic load,
   input  logic en,
   output logic expire
);
   localparam int CW = $clog2(LIMIT + 1);

   logic [CW-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load)
         cnt_d = '0;
      else if (en)
         cnt_d = cnt_q + 1'b1;
   end

   assign expire = en && (cnt_q == CW'(LIMIT - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         cnt_q <= '0;
      else
         cnt_q <= cnt_d;
   end
endmodule

// File: rtl/capture_buffer_master.sv
// I/Q capture buffer initiator: writes a sample stream into buffer entries
// 0..len-1, or reads them back out as a stream with a last flag.
module capture_buffer_master
   import caf_axi_pkg::*;
#(
   parameter int BUFFER_LENGTH  = CAF_BUFFER_LENGTH,
   parameter int INDEX_BITS     = CAF_INDEX_BITS,
   parameter int I_BITS         = CAF_I_BITS,
   parameter int Q_BITS         = CAF_Q_BITS,
   parameter int TIMEOUT_CYCLES = CAF_TIMEOUT_CYCLES
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start_capture,
   input  logic                  start_readout,
   input  logic [INDEX_BITS-1:0] xfer_len,
   input  logic [I_BITS-1:0]     in_i,
   input  logic [Q_BITS-1:0]     in_q,
   input  logic                  in_valid,
   output logic                  in_ready,
   output logic [I_BITS-1:0]     out_i,
   output logic [Q_BITS-1:0]     out_q,
   output logic                  out_valid,
   output logic                  out_last,
   input  logic                  out_ready,
   output logic                  busy,
   output logic                  done,
   output logic                  error,
   capture_buffer_master_if.master bus
);
   localparam int IQ_W = I_BITS + Q_BITS;

   state_e                state_q, state_d;
   logic [INDEX_BITS-1:0] len_q, len_d, addr_q, addr_d;
   logic [INDEX_BITS-1:0] waddr_q, waddr_d, raddr_q, raddr_d;
   logic [IQ_W-1:0]       wdata_q, wdata_d;
   logic [I_BITS-1:0]     out_i_q, out_i_d;
   logic [Q_BITS-1:0]     out_q_q, out_q_d;
   logic wvalid_q, wvalid_d, rvalid_q, rvalid_d, rready_q, rready_d;
   logic bready_q, bready_d, in_ready_q, in_ready_d;
   logic out_valid_q, out_valid_d, out_last_q, out_last_d;
   logic busy_q, busy_d, done_q, done_d, error_q, error_d;
   logic tmo_load, tmo_en, tmo_expire;
   logic bresp_unused;

   assign bresp_unused = bus.s_axi_bresp;

   // Watchdog runs only while waiting on the responder; any other state rearms it.
   assign tmo_load = !(state_q inside {WR_RESP, RD_WAIT, RD_ACK});
   assign tmo_en   = (state_q == WR_RESP && !bus.s_axi_bvalid) ||
                     (state_q == RD_WAIT && !bus.s_axi_rvalid) ||
                     (state_q == RD_ACK  &&  bus.s_axi_rvalid);

   timeout_counter #(.LIMIT(TIMEOUT_CYCLES)) u_tmo (
      .clk    (clk),
      .rst_n  (rst_n),
      .load   (tmo_load),
      .en     (tmo_en),
      .expire (tmo_expire)
   );

   always_comb begin
      state_d  = state_q;
      len_d    = len_q;
      addr_d   = addr_q;
      error_d  = error_q;
      wdata_d  = wdata_q;
      waddr_d  = waddr_q;
      raddr_d  = raddr_q;
      out_i_d  = out_i_q;
      out_q_d  = out_q_q;
      wvalid_d = 1'b0;
      rvalid_d = 1'b0;
      rready_d = 1'b0;
      unique case (state_q)
         IDLE: if (start_capture || start_readout) begin
            len_d   = INDEX_BITS'(clamp_len(int'(xfer_len), BUFFER_LENGTH));
            addr_d  = '0;
            error_d = 1'b0;
            state_d = start_capture ? WR_ACCEPT : RD_REQ;
         end
         WR_ACCEPT: if (in_valid) begin
            wdata_d = {in_i, in_q};
            state_d = WR_REQ;
         end
         WR_REQ: if (bus.s_axi_wready) begin
            wvalid_d = 1'b1;
            waddr_d  = addr_q;
            state_d  = WR_RESP;
         end
         WR_RESP: if (bus.s_axi_bvalid) begin
            addr_d  = addr_q + 1'b1;
            state_d = (addr_d == len_q) ? DONE : WR_ACCEPT;
         end
         // A read response left over from the previous entry must clear first.
         RD_REQ: if (!bus.s_axi_rvalid && bus.s_axi_rready) begin
            rvalid_d = 1'b1;
            raddr_d  = addr_q;
            state_d  = RD_WAIT;
         end
         RD_WAIT: if (bus.s_axi_rvalid) begin
            out_i_d = bus.s_i;
            out_q_d = bus.s_q;
            state_d = RD_OUT;
         end
         RD_OUT: if (out_ready) begin
            rready_d = 1'b1;
            state_d  = RD_ACK;
         end
         RD_ACK: if (!bus.s_axi_rvalid) begin
            addr_d  = addr_q + 1'b1;
            state_d = (addr_d == len_q) ? DONE : RD_REQ;
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
      if (tmo_expire) begin
         error_d = 1'b1;
         state_d = DONE;
      end
      // Outputs decode the next state so they are registered yet aligned with it.
      in_ready_d  = (state_d == WR_ACCEPT);
      bready_d    = (state_d == WR_RESP);
      out_valid_d = (state_d == RD_OUT);
      out_last_d  = out_valid_d && (addr_q == INDEX_BITS'(len_q - 1'b1));
      busy_d      = (state_d != IDLE);
      done_d      = (state_d == DONE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         len_q       <= '0;
         addr_q      <= '0;
         error_q     <= 1'b0;
         wdata_q     <= '0;
         waddr_q     <= '0;
         raddr_q     <= '0;
         out_i_q     <= '0;
         out_q_q     <= '0;
         wvalid_q    <= 1'b0;
         rvalid_q    <= 1'b0;
         rready_q    <= 1'b0;
         bready_q    <= 1'b0;
         in_ready_q  <= 1'b0;
         out_valid_q <= 1'b0;
         out_last_q  <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         len_q       <= len_d;
         addr_q      <= addr_d;
         error_q     <= error_d;
         wdata_q     <= wdata_d;
         waddr_q     <= waddr_d;
         raddr_q     <= raddr_d;
         out_i_q     <= out_i_d;
         out_q_q     <= out_q_d;
         wvalid_q    <= wvalid_d;
         rvalid_q    <= rvalid_d;
         rready_q    <= rready_d;
         bready_q    <= bready_d;
         in_ready_q  <= in_ready_d;
         out_valid_q <= out_valid_d;
         out_last_q  <= out_last_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
      end
   end

   assign in_ready         = in_ready_q;
   assign out_i            = out_i_q;
   assign out_q            = out_q_q;
   assign out_valid        = out_valid_q;
   assign out_last         = out_last_q;
   assign busy             = busy_q;
   assign done             = done_q;
   assign error            = error_q;
   assign bus.m_axi_waddr  = waddr_q;
   assign bus.m_axi_wvalid = wvalid_q;
   assign bus.m_axi_wdata  = wdata_q;
   assign bus.m_axi_bready = bready_q;
   assign bus.m_axi_raddr  = raddr_q;
   assign bus.m_axi_rvalid = rvalid_q;
   assign bus.m_axi_rready = rready_q;
endmodule

// File: tb/tb_capture_buffer_master.sv
// Directed bench for capture_buffer_master with a one-cycle-latency buffer
// responder model and a stream monitor.
module tb_capture_buffer_master;
   localparam int IB = 4;
   localparam int IW = 12;
   localparam int QW = 12;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic          start_capture = 1'b0, start_readout = 1'b0;
   logic [IB-1:0] xfer_len = '0;
   logic [IW-1:0] in_i, out_i;
   logic [QW-1:0] in_q, out_q;
   logic          in_valid = 1'b0, in_ready;
   logic          out_valid, out_last, out_ready = 1'b1;
   logic          busy, done, error;

   capture_buffer_master_if #(.INDEX_BITS(IB), .I_BITS(IW), .Q_BITS(QW)) bus ();

   capture_buffer_master dut (
      .clk(clk), .rst_n(rst_n),
      .start_capture(start_capture), .start_readout(start_readout),
      .xfer_len(xfer_len),
      .in_i(in_i), .in_q(in_q), .in_valid(in_valid), .in_ready(in_ready),
      .out_i(out_i), .out_q(out_q), .out_valid(out_valid), .out_last(out_last),
      .out_ready(out_ready),
      .busy(busy), .done(done), .error(error),
      .bus(bus)
   );

   // Responder: write ack and read data one cycle after the request.
   logic          bv_en = 1'b1;
   logic [23:0]   mem [16];
   assign bus.s_axi_wready = 1'b1;
   assign bus.s_axi_rready = 1'b1;
   assign bus.s_axi_bresp  = 1'b0;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bus.s_axi_bvalid <= 1'b0;
         bus.s_axi_rvalid <= 1'b0;
         bus.s_i <= '0;
         bus.s_q <= '0;
      end else begin
         if (bus.m_axi_wvalid) begin
            mem[bus.m_axi_waddr] <= bus.m_axi_wdata;
            if (bv_en) bus.s_axi_bvalid <= 1'b1;
         end else if (bus.s_axi_bvalid && bus.m_axi_bready)
            bus.s_axi_bvalid <= 1'b0;
         if (bus.m_axi_rvalid) begin
            bus.s_axi_rvalid <= 1'b1;
            bus.s_i <= mem[bus.m_axi_raddr][23:12];
            bus.s_q <= mem[bus.m_axi_raddr][11:0];
         end else if (bus.m_axi_rready)
            bus.s_axi_rvalid <= 1'b0;
      end
   end

   // Source stream is (k,-k) for k = 1,2,3...
   logic [3:0] cap_idx;
   always_comb begin
      in_i = 12'(cap_idx) + 12'd1;
      in_q = -(12'(cap_idx) + 12'd1);
   end

   logic        cnt_clr = 1'b1;
   int          wcount, rreq, done_cnt, bready_cyc, overlap, stall_bad, stall_chk, nout;
   logic [23:0] got [16];
   logic [15:0] last_mask;
   logic        hold_v;
   logic [24:0] hold_d;

   always @(posedge clk) begin
      if (cnt_clr) begin
         wcount <= 0; rreq <= 0; done_cnt <= 0; bready_cyc <= 0; overlap <= 0;
         stall_bad <= 0; stall_chk <= 0; nout <= 0; last_mask <= '0;
         cap_idx <= '0; hold_v <= 1'b0; hold_d <= '0;
      end else begin
         if (bus.m_axi_wvalid) wcount <= wcount + 1;
         if (bus.m_axi_rvalid) rreq <= rreq + 1;
         if (done) done_cnt <= done_cnt + 1;
         if (bus.m_axi_bready) bready_cyc <= bready_cyc + 1;
         if (bus.m_axi_wvalid && bus.m_axi_rvalid) overlap <= overlap + 1;
         if (in_valid && in_ready) cap_idx <= cap_idx + 4'd1;
         if (out_valid && out_ready) begin
            got[nout[3:0]] <= {out_i, out_q};
            last_mask[nout[3:0]] <= out_last;
            nout <= nout + 1;
         end
         if (hold_v) begin
            stall_chk <= stall_chk + 1;
            if (!out_valid || hold_d !== {out_i, out_q, out_last}) stall_bad <= stall_bad + 1;
         end
         hold_v <= out_valid && !out_ready;
         hold_d <= {out_i, out_q, out_last};
      end
   end

   int checks = 0;
   int errors = 0;

   function automatic logic [23:0] iq(input int v);
      return {12'(v), 12'(-v)};
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic clr();
      @(negedge clk); cnt_clr = 1'b1;
      @(negedge clk); cnt_clr = 1'b0;
   endtask

   task automatic start(input logic cap, input logic rd, input logic [IB-1:0] len);
      @(negedge clk);
      xfer_len = len; start_capture = cap; start_readout = rd;
      @(negedge clk);
      start_capture = 1'b0; start_readout = 1'b0;
   endtask

   task automatic wait_done(input string tag, input int max);
      int n;
      n = 0;
      while (!done && n < max) begin @(negedge clk); n++; end
      chk({tag, "_done"}, 64'(done), 64'd1);
      @(negedge clk);
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_outs"}, 64'({in_ready, out_i, out_q, out_valid, out_last, busy, done, error}), 64'd0);
      chk({tag, "_bus"}, 64'({bus.m_axi_waddr, bus.m_axi_wvalid, bus.m_axi_wdata, bus.m_axi_bready,
                              bus.m_axi_raddr, bus.m_axi_rvalid, bus.m_axi_rready}), 64'd0);
   endtask

   initial begin
      int n;
      repeat (3) @(negedge clk);
      chk_zero("reset");
      rst_n = 1'b1; cnt_clr = 1'b0;
      @(negedge clk);
      chk_zero("idle");

      // Capture four samples with in_valid held high.
      in_valid = 1'b1;
      clr(); start(1'b1, 1'b0, 4'd4);
      wait_done("cap4", 60);
      chk("cap4_writes", 64'(wcount), 64'd4);
      chk("cap4_done_cnt", 64'(done_cnt), 64'd1);
      chk("cap4_error", 64'(error), 64'd0);
      chk("cap4_busy", 64'(busy), 64'd0);
      for (int k = 0; k < 4; k++) chk($sformatf("cap4_mem%0d", k), 64'(mem[k]), 64'(iq(k + 1)));

      // Read them back, stalling one cycle on every sample.
      clr(); start(1'b0, 1'b1, 4'd4);
      n = 0;
      while (!done && n < 200) begin
         out_ready = out_valid ? ~out_ready : 1'b1;
         @(negedge clk); n++;
      end
      chk("rd4_done", 64'(done), 64'd1);
      out_ready = 1'b1;
      @(negedge clk);
      chk("rd4_count", 64'(nout), 64'd4);
      for (int k = 0; k < 4; k++) chk($sformatf("rd4_data%0d", k), 64'(got[k]), 64'(iq(k + 1)));
      chk("rd4_last", 64'(last_mask[3:0]), 64'b1000);
      chk("rd4_stalled", 64'(stall_chk != 0), 64'd1);
      chk("rd4_stable", 64'(stall_bad), 64'd0);
      chk("rd4_overlap", 64'(overlap), 64'd0);
      chk("rd4_writes", 64'(wcount), 64'd0);

      // xfer_len=0 clamps to the full buffer; starts while busy are ignored.
      clr(); start(1'b1, 1'b0, 4'd0);
      repeat (5) @(negedge clk);
      start(1'b1, 1'b1, 4'd2);
      wait_done("len0", 200);
      chk("len0_writes", 64'(wcount), 64'd10);
      chk("len0_rreq", 64'(rreq), 64'd0);
      chk("len0_done_cnt", 64'(done_cnt), 64'd1);
      for (int k = 0; k < 10; k++) chk($sformatf("len0_mem%0d", k), 64'(mem[k]), 64'(iq(k + 1)));

      // Responder never acks a write: timeout after 16 waiting cycles.
      bv_en = 1'b0;
      clr(); start(1'b1, 1'b0, 4'd1);
      wait_done("tmo", 80);
      chk("tmo_bready_cycles", 64'(bready_cyc), 64'd16);
      chk("tmo_error", 64'(error), 64'd1);
      chk("tmo_done_cnt", 64'(done_cnt), 64'd1);
      chk("tmo_busy", 64'(busy), 64'd0);
      repeat (3) @(negedge clk);
      chk("tmo_sticky", 64'(error), 64'd1);
      bv_en = 1'b1;
      clr(); start(1'b1, 1'b0, 4'd1);
      chk("tmo_cleared", 64'(error), 64'd0);
      wait_done("tmo_retry", 40);
      chk("tmo_retry_error", 64'(error), 64'd0);

      // Reset while presenting a readout sample.
      out_ready = 1'b0;
      clr(); start(1'b0, 1'b1, 4'd4);
      n = 0;
      while (!out_valid && n < 50) begin @(negedge clk); n++; end
      chk("rst_rd_out", 64'(out_valid), 64'd1);
      rst_n = 1'b0;
      #1;
      chk_zero("rst_async");
      @(negedge clk); @(negedge clk);
      chk("rst_no_done", 64'(done_cnt), 64'd0);
      rst_n = 1'b1; out_ready = 1'b1;
      clr(); start(1'b0, 1'b1, 4'd2);
      n = 0;
      while (!bus.m_axi_rvalid && n < 20) begin @(negedge clk); n++; end
      chk("rst_rvalid", 64'(bus.m_axi_rvalid), 64'd1);
      chk("rst_raddr", 64'(bus.m_axi_raddr), 64'd0);
      wait_done("rst_rd2", 80);
      chk("rst_rd2_count", 64'(nout), 64'd2);
      chk("rst_rd2_data0", 64'(got[0]), 64'(iq(1)));
      chk("rst_rd2_data1", 64'(got[1]), 64'(iq(2)));
      chk("rst_rd2_last", 64'(last_mask[1:0]), 64'b10);

      // Both starts together: capture wins.
      clr(); start(1'b1, 1'b1, 4'd3);
      wait_done("both", 80);
      chk("both_writes", 64'(wcount), 64'd3);
      chk("both_rreq", 64'(rreq), 64'd0);
      chk("both_error", 64'(error), 64'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
